// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave register-access controller.
package i2c_pkg;

  localparam int unsigned ByteW = 8;

  // One-hot, matching the encoding style of the slave control FSM.
  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StArmed = 4'b0010,
    StWrite = 4'b0100,
    StRead  = 4'b1000
  } reg_ctrl_state_t;

endpackage

// File: rtl/i2c_slave_reg_ctrl_if.sv
// Host access port and register bank port of the I2C register controller.
interface i2c_slave_reg_ctrl_if #(
  parameter int unsigned REG_DEPTH = 16
) ();
  import i2c_pkg::*;

  localparam int unsigned ADDR_W = $clog2(REG_DEPTH);

  // Host side
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [ByteW-1:0]  host_wdata;
  logic              host_gnt;
  logic [ByteW-1:0]  host_rdata;
  logic              host_rvld;

  // Register bank side
  logic              reg_we;
  logic              reg_re;
  logic [ADDR_W-1:0] reg_addr;
  logic [ByteW-1:0]  reg_wdata;
  logic [ByteW-1:0]  reg_rdata;

  // Controller view
  modport slave (
    input  host_req, host_we, host_addr, host_wdata, reg_rdata,
    output host_gnt, host_rdata, host_rvld, reg_we, reg_re, reg_addr, reg_wdata
  );

  // Environment view: host plus register bank
  modport master (
    output host_req, host_we, host_addr, host_wdata, reg_rdata,
    input  host_gnt, host_rdata, host_rvld, reg_we, reg_re, reg_addr, reg_wdata
  );

endinterface

// File: rtl/reg_port_arbiter.sv
// Fixed-priority sharing of the single register bank port:
// pending I2C write, then pending I2C read, then the host.
module reg_port_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              wr_pend_i,
  input  logic              rd_pend_i,
  input  logic [ADDR_W-1:0] ptr_i,
  input  logic [ByteW-1:0]  wr_data_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [ByteW-1:0]  host_wdata_i,
  output logic              reg_we_o,
  output logic              reg_re_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [ByteW-1:0]  reg_wdata_o,
  output logic              host_gnt_o
);

  // Port mux: I2C pends always win, host only gets an otherwise idle cycle.
  always_comb begin
    reg_we_o    = 1'b0;
    reg_re_o    = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    host_gnt_o  = host_req_i & ~wr_pend_i & ~rd_pend_i;
    if (wr_pend_i) begin
      reg_we_o    = 1'b1;
      reg_addr_o  = ptr_i;
      reg_wdata_o = wr_data_i;
    end else if (rd_pend_i) begin
      reg_re_o   = 1'b1;
      reg_addr_o = ptr_i;
    end else if (host_req_i) begin
      reg_we_o    = host_we_i;
      reg_re_o    = ~host_we_i;
      reg_addr_o  = host_addr_i;
      reg_wdata_o = host_wdata_i;
    end
  end

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// I2C slave register-access controller: pointer load, auto-incrementing
// writes and read fetches, sharing the register bank port with a host.
module i2c_slave_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned REG_DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(REG_DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start_Condition,
  input  logic               Stop_Condition,
  input  logic               data_vld,
  input  logic [ByteW-1:0]   rx_data,
  input  logic               byte_req,
  output logic [ByteW-1:0]   tx_data,
  output logic               tx_vld,
  output logic               busy,
  i2c_slave_reg_ctrl_if.slave bus
);

  reg_ctrl_state_t   state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ByteW-1:0]  wr_data_q, wr_data_d;
  logic              tx_vld_q;
  logic [ByteW-1:0]  tx_data_q;
  logic              host_rvld_q;
  logic [ByteW-1:0]  host_rdata_q;
  logic              issue_wr, issue_rd, rd_req, host_gnt;

  // Pends never overlap in practice; if they did, the write goes first.
  assign issue_wr = wr_pend_q;
  assign issue_rd = rd_pend_q & ~wr_pend_q;
  // A received byte takes precedence over a simultaneous read request.
  assign rd_req   = byte_req & ~data_vld & (state_q != StIdle);

  // Next state, pointer and pend flags.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_pend_d = wr_pend_q & ~issue_wr;
    rd_pend_d = rd_pend_q & ~issue_rd;
    wr_data_d = wr_data_q;
    if (issue_wr || issue_rd) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
    if (data_vld) begin
      unique case (state_q)
        StArmed: begin
          ptr_d   = rx_data[ADDR_W-1:0];
          state_d = StWrite;
        end
        StWrite: begin
          wr_pend_d = 1'b1;
          wr_data_d = rx_data;
        end
        default: ;
      endcase
    end
    if (rd_req) begin
      rd_pend_d = 1'b1;
      state_d   = StRead;
    end
    // Bus conditions override the byte-driven transition; the byte itself
    // was already handled under the current state above.
    if (Start_Condition) begin
      state_d = StArmed;
    end else if (Stop_Condition) begin
      state_d = StIdle;
    end
  end

  // State registers and read-data capture.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      wr_data_q    <= '0;
      tx_vld_q     <= 1'b0;
      tx_data_q    <= '0;
      host_rvld_q  <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      wr_data_q   <= wr_data_d;
      tx_vld_q    <= issue_rd;
      host_rvld_q <= host_gnt & ~bus.host_we;
      if (tx_vld_q) begin
        tx_data_q <= bus.reg_rdata;
      end
      if (host_rvld_q) begin
        host_rdata_q <= bus.reg_rdata;
      end
    end
  end

  // Bank data is live in the valid cycle, then held in the capture register.
  assign tx_vld          = tx_vld_q;
  assign tx_data         = tx_vld_q ? bus.reg_rdata : tx_data_q;
  assign bus.host_rvld   = host_rvld_q;
  assign bus.host_rdata  = host_rvld_q ? bus.reg_rdata : host_rdata_q;
  assign bus.host_gnt    = host_gnt;
  assign busy            = (state_q != StIdle);

  reg_port_arbiter #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .wr_pend_i    (wr_pend_q),
    .rd_pend_i    (rd_pend_q),
    .ptr_i        (ptr_q),
    .wr_data_i    (wr_data_q),
    .host_req_i   (bus.host_req),
    .host_we_i    (bus.host_we),
    .host_addr_i  (bus.host_addr),
    .host_wdata_i (bus.host_wdata),
    .reg_we_o     (bus.reg_we),
    .reg_re_o     (bus.reg_re),
    .reg_addr_o   (bus.reg_addr),
    .reg_wdata_o  (bus.reg_wdata),
    .host_gnt_o   (host_gnt)
  );

endmodule
